cache_fill_arbiter: RTL and testbench
=====================================

# cache_fill_arbiter

Parametrised main-memory arbiter sitting between N cache channels and the single multicycle, pipelined main memory. It is the generalisation of the two-port instruction/data cache arbiter to NUM_CH channels and configurable block size. It adds round-robin fairness, pipelined block-fill issue and write-through servicing through the same grant path. It serialises all memory traffic and drives the global `stall_n`.

## Interface
- `NUM_CH`, 2, number of cache channels (channel 0 = icache, 1 = dcache by convention)
- `ADDR_W`, 16, byte address width
- `DATA_W`, 16, word width (2-byte words)
- `WORDS_PER_BLOCK`, 8, words per cache block; power of two, ≥2
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `miss_req` input NUM_CH: per-channel fill request, level, held until `tag_wr[i]` pulse
- `miss_addr` input NUM_CH*ADDR_W: per-channel miss address, slice i = [i*ADDR_W +: ADDR_W]
- `wr_req` input NUM_CH: per-channel write-through request, level, held until `wr_ack[i]`
- `wr_addr` input NUM_CH*ADDR_W: per-channel write address
- `wr_data` input NUM_CH*DATA_W: per-channel write data
- `fill_data` output DATA_W: returned word, shared by all channels
- `fill_addr` output ADDR_W: address of `fill_data`
- `data_wr` output NUM_CH: one-hot, write `fill_data` into channel i's data array
- `tag_wr` output NUM_CH: one-hot, write tag/valid for channel i; coincides with the last `data_wr`
- `wr_ack` output NUM_CH: one-cycle pulse, write-through for channel i committed
- `busy` output NUM_CH: channel i currently granted
- `stall_n` output 1: low while any fill is pending or in progress
- `mainmem_addr` output ADDR_W, `mainmem_wr` output 1, `mainmem_write_data` output DATA_W, `mainmem_enable` output 1
- `mainmem_read_data` input DATA_W, `mainmem_data_valid` input 1

## Operation
- States: IDLE, WRITE, FILL, DRAIN.
- IDLE: the request vector is req[i] = miss_req[i] | wr_req[i]. The grant goes to the first requesting i at or after `rr_ptr`, searching circularly. The winner is registered in `gnt`.
  - If `wr_req[gnt]` is set, go to WRITE. Write has priority over a miss within the same channel.
  - Otherwise go to FILL.
  - No request: stay in IDLE.
- WRITE (1 cycle):
  - `mainmem_addr`=wr_addr[gnt], `mainmem_write_data`=wr_data[gnt], `mainmem_wr`=1, `mainmem_enable`=1.
  - `wr_ack[gnt]` pulses. `rr_ptr` ← gnt+1 mod NUM_CH. Go to IDLE.
- FILL:
  - Block base = miss_addr[gnt] with low log2(WORDS_PER_BLOCK)+1 bits cleared.
  - One read is issued per cycle: `mainmem_addr` = base + 2*issue_cnt, `mainmem_enable`=1, `mainmem_wr`=0.
  - `issue_cnt` increments each cycle. After issue_cnt = WORDS_PER_BLOCK−1 is issued, go to DRAIN.
- FILL/DRAIN return path: each cycle with `mainmem_data_valid`=1:
  - `fill_data`=mainmem_read_data, `fill_addr`=base + 2*ret_cnt, `data_wr[gnt]`=1, ret_cnt++.
  - When ret_cnt = WORDS_PER_BLOCK−1, also assert `tag_wr[gnt]`. Then `rr_ptr` ← gnt+1 and go to IDLE.
- `busy[i]` = (state≠IDLE) & gnt==i.
- `stall_n` = ~(|miss_req) & (state ∈ {IDLE, WRITE}).
- `mainmem_enable`=0 and `mainmem_wr`=0 in IDLE and DRAIN.
- Counters are log2(WORDS_PER_BLOCK) bits and cleared on grant. Address adds wrap modulo 2^ADDR_W.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, gnt=0, counters=0.
  - All `data_wr`/`tag_wr`/`wr_ack`/`busy`=0, `stall_n`=1.
  - `fill_data`/`fill_addr`/`mainmem_addr`/`mainmem_write_data`=0, `mainmem_wr`=`mainmem_enable`=0.
- Outputs are combinational from registered state/counters plus `mainmem_data_valid`. Grant decision is registered.
- Write-through latency: request seen in IDLE at cycle T; WRITE and `wr_ack` at T+1; IDLE at T+2.
- Fill latency with memory latency L: grant at T. Reads issue T+1…T+W. Returns arrive T+1+L…T+W+L. `tag_wr` at T+W+L. Earliest new grant evaluated at T+W+L+1.
- Returns overlapping issue cycles are accepted in FILL without stalling issue.
- `mainmem_data_valid` in IDLE or WRITE is ignored (stray return after reset).
- Async reset mid-fill aborts immediately. No `tag_wr` is produced, so the cache line stays invalid. The requester re-requests after reset.
- Requests dropping before completion are a protocol violation. The arbiter still completes the granted transaction.

## Test plan
- Single icache miss at 0x0013, W=8, L=4 → reads 0x0010…0x001E on 8 consecutive cycles. 8 `data_wr[0]` pulses with matching `fill_addr`. `tag_wr[0]` on the 8th. `stall_n` low from request to `tag_wr`+1.
- Simultaneous miss on ch0 and ch1 from reset → ch0 fills first, then ch1 is granted in the cycle after returning to IDLE. A repeat with both requests pending after that grants ch0 again (round-robin).
- ch1 `wr_req` addr 0x4002 data 0xBEEF while ch0 fill in progress → write waits. Then WRITE with `mainmem_wr`=1, addr 0x4002, data 0xBEEF, `wr_ack[1]` for one cycle. `stall_n` stays high during the write.
- Same channel asserting `wr_req` and `miss_req` together → WRITE serviced first, then FILL.
- `rst_n` pulled low at 3rd return of a fill → all outputs at reset values asynchronously. No `tag_wr`. Late `mainmem_data_valid` pulses after release produce no `data_wr`.
- NUM_CH=4, WORDS_PER_BLOCK=4, all four channels missing → grants in order 0,1,2,3. Each gets 4 returns and one `tag_wr`, with base address aligned to 8 bytes.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Round-robin arbiter between NUM_CH cache channels and one pipelined main memory:
// serialises write-throughs and pipelined block fills, and drives the global stall_n.
module cache_fill_arbiter #(
   parameter int NUM_CH          = 2,
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          miss_req,
   input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
   input  logic [NUM_CH-1:0]          wr_req,
   input  logic [NUM_CH*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_CH*DATA_W-1:0]   wr_data,
   output logic [DATA_W-1:0]          fill_data,
   output logic [ADDR_W-1:0]          fill_addr,
   output logic [NUM_CH-1:0]          data_wr,
   output logic [NUM_CH-1:0]          tag_wr,
   output logic [NUM_CH-1:0]          wr_ack,
   output logic [NUM_CH-1:0]          busy,
   output logic                       stall_n,
   output logic [ADDR_W-1:0]          mainmem_addr,
   output logic                       mainmem_wr,
   output logic [DATA_W-1:0]          mainmem_write_data,
   output logic                       mainmem_enable,
   input  logic [DATA_W-1:0]          mainmem_read_data,
   input  logic                       mainmem_data_valid
);

   localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int OFS_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [PTR_W-1:0]    gnt_r, rr_ptr_r, pick_s;
   logic [CNT_W-1:0]    issue_cnt_r, ret_cnt_r;
   logic [ADDR_W-1:0]   base_r;
   logic [NUM_CH-1:0]   req_s;
   logic                ret_fire_s, ret_last_s;

   logic [ADDR_W-1:0]   miss_addr_a [NUM_CH];
   logic [ADDR_W-1:0]   wr_addr_a   [NUM_CH];
   logic [DATA_W-1:0]   wr_data_a   [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign miss_addr_a[i] = miss_addr[i*ADDR_W +: ADDR_W];
      assign wr_addr_a[i]   = wr_addr[i*ADDR_W +: ADDR_W];
      assign wr_data_a[i]   = wr_data[i*DATA_W +: DATA_W];
   end

   // First requesting channel at or after ptr, searching circularly.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [PTR_W-1:0]  ptr);
      logic [PTR_W-1:0] pick;
      logic [PTR_W:0]   idx;
      logic             found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(NUM_CH)) begin
            idx = idx - (PTR_W+1)'(NUM_CH);
         end
         if (!found && req[idx[PTR_W-1:0]]) begin
            pick  = idx[PTR_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
      logic [PTR_W-1:0] nxt;
      if (cur == PTR_W'(NUM_CH - 1)) begin
         nxt = '0;
      end else begin
         nxt = cur + PTR_W'(1);
      end
      return nxt;
   endfunction

   assign req_s      = miss_req | wr_req;
   assign pick_s     = rr_pick(req_s, rr_ptr_r);
   // Stray returns outside FILL/DRAIN (e.g. after a reset mid-fill) are dropped here.
   assign ret_fire_s = mainmem_data_valid & ((state_r == ST_FILL) | (state_r == ST_DRAIN));
   assign ret_last_s = (ret_cnt_r == CNT_LAST);

   // State, grant, round-robin pointer, block base and issue/return counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         gnt_r       <= '0;
         rr_ptr_r    <= '0;
         issue_cnt_r <= '0;
         ret_cnt_r   <= '0;
         base_r      <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            ST_IDLE: begin
               if (|req_s) begin
                  gnt_r       <= pick_s;
                  base_r      <= miss_addr_a[pick_s] & BASE_MASK;
                  issue_cnt_r <= '0;
                  ret_cnt_r   <= '0;
               end
            end
            ST_WRITE: begin
               rr_ptr_r <= next_ptr(gnt_r);
            end
            ST_FILL, ST_DRAIN: begin
               if (state_r == ST_FILL) begin
                  issue_cnt_r <= issue_cnt_r + CNT_W'(1);
               end
               if (ret_fire_s) begin
                  ret_cnt_r <= ret_cnt_r + CNT_W'(1);
                  if (ret_last_s) begin
                     rr_ptr_r <= next_ptr(gnt_r);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Next state plus all memory-side and cache-side outputs.
   always_comb begin
      state_s            = state_r;
      fill_data          = '0;
      fill_addr          = '0;
      data_wr            = '0;
      tag_wr             = '0;
      wr_ack             = '0;
      busy               = '0;
      mainmem_addr       = '0;
      mainmem_wr         = 1'b0;
      mainmem_write_data = '0;
      mainmem_enable     = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (|req_s) begin
               state_s = wr_req[pick_s] ? ST_WRITE : ST_FILL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mainmem_addr       = wr_addr_a[gnt_r];
            mainmem_write_data = wr_data_a[gnt_r];
            mainmem_wr         = 1'b1;
            mainmem_enable     = 1'b1;
            wr_ack[gnt_r]      = 1'b1;
            state_s            = ST_IDLE;
         end
         ST_FILL: begin
            mainmem_enable = 1'b1;
            mainmem_addr   = base_r + ADDR_W'({issue_cnt_r, 1'b0});
            if (issue_cnt_r == CNT_LAST) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_DRAIN: begin
            state_s = ST_DRAIN;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (ret_fire_s) begin
         fill_data      = mainmem_read_data;
         fill_addr      = base_r + ADDR_W'({ret_cnt_r, 1'b0});
         data_wr[gnt_r] = 1'b1;
         if (ret_last_s) begin
            tag_wr[gnt_r] = 1'b1;
            state_s       = ST_IDLE;
         end else begin
            tag_wr = '0;
         end
      end else begin
         data_wr = '0;
      end

      if (state_r != ST_IDLE) begin
         busy[gnt_r] = 1'b1;
      end else begin
         busy = '0;
      end
   end

   assign stall_n = ~(|miss_req) & ((state_r == ST_IDLE) | (state_r == ST_WRITE));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: a 2-channel/8-word instance (memory latency 4)
// and a 4-channel/4-word instance (memory latency 2), each with its own memory model.
module tb_cache_fill_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      int          ch;
      logic [15:0] addr;
      logic [15:0] data;
      bit          tag;
      bit          stall;
   } exp_t;

   exp_t sb0[$];
   exp_t sb4[$];
   int   n_cmp      = 0;
   int   n_bad      = 0;
   int   ret_seen   = 0;
   int   late_valid = 0;

   // two-channel instance
   logic [1:0]  miss_req, wr_req, data_wr, tag_wr, wr_ack, busy;
   logic [31:0] miss_addr, wr_addr, wr_data;
   logic [15:0] fill_data, fill_addr, mainmem_addr, mainmem_write_data, mainmem_read_data;
   logic        stall_n, mainmem_wr, mainmem_enable, mainmem_data_valid;

   // four-channel instance
   logic [3:0]  miss_req4, wr_req4, data_wr4, tag_wr4, wr_ack4, busy4;
   logic [63:0] miss_addr4, wr_addr4, wr_data4;
   logic [15:0] fill_data4, fill_addr4, mm_addr4, mm_wdata4, mm_rdata4;
   logic        stall_n4, mm_wr4, mm_en4, mm_valid4;

   cache_fill_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .miss_req(miss_req), .miss_addr(miss_addr),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .fill_data(fill_data), .fill_addr(fill_addr),
      .data_wr(data_wr), .tag_wr(tag_wr), .wr_ack(wr_ack), .busy(busy), .stall_n(stall_n),
      .mainmem_addr(mainmem_addr), .mainmem_wr(mainmem_wr),
      .mainmem_write_data(mainmem_write_data), .mainmem_enable(mainmem_enable),
      .mainmem_read_data(mainmem_read_data), .mainmem_data_valid(mainmem_data_valid)
   );

   cache_fill_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .miss_req(miss_req4), .miss_addr(miss_addr4),
      .wr_req(wr_req4), .wr_addr(wr_addr4), .wr_data(wr_data4),
      .fill_data(fill_data4), .fill_addr(fill_addr4),
      .data_wr(data_wr4), .tag_wr(tag_wr4), .wr_ack(wr_ack4), .busy(busy4), .stall_n(stall_n4),
      .mainmem_addr(mm_addr4), .mainmem_wr(mm_wr4),
      .mainmem_write_data(mm_wdata4), .mainmem_enable(mm_en4),
      .mainmem_read_data(mm_rdata4), .mainmem_data_valid(mm_valid4)
   );

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a ^ 16'hC35A;
   endfunction

   // memory models: fixed-latency read pipelines, not reset, so stale returns survive a reset
   logic [3:0]  mv0 = 4'b0000;
   logic [15:0] md0 [4];
   logic [1:0]  mv4 = 2'b00;
   logic [15:0] md4 [2];
   always @(posedge clk) begin
      mv0    <= {mv0[2:0], mainmem_enable & ~mainmem_wr};
      md0[0] <= mem_f(mainmem_addr);
      md0[1] <= md0[0];
      md0[2] <= md0[1];
      md0[3] <= md0[2];
      mv4    <= {mv4[0], mm_en4 & ~mm_wr4};
      md4[0] <= mem_f(mm_addr4);
      md4[1] <= md4[0];
   end
   assign mainmem_data_valid = mv0[3];
   assign mainmem_read_data  = md0[3];
   assign mm_valid4          = mv4[1];
   assign mm_rdata4          = md4[1];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic sb_cmp(input string who, input exp_t e, input logic [3:0] dwr,
                         input logic [3:0] twr, input logic [3:0] wack, input logic mwr,
                         input logic [15:0] maddr, input logic [15:0] mwd,
                         input logic [15:0] faddr, input logic [15:0] fdata, input logic stl);
      logic [3:0] oh;
      bit         ok;
      oh = 4'b0001 << e.ch;
      n_cmp++;
      if (e.is_wr)
         ok = (wack == oh) && (mwr == 1'b1) && (maddr == e.addr) && (mwd == e.data)
              && (dwr == 4'b0000) && (stl == e.stall);
      else
         ok = (dwr == oh) && (twr == (e.tag ? oh : 4'b0000)) && (wack == 4'b0000)
              && (mwr == 1'b0) && (faddr == e.addr) && (fdata == e.data);
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_%s ch%0d: got data_wr=%b tag_wr=%b wr_ack=%b mm_wr=%b mm_addr=%h mm_wdata=%h fill_addr=%h fill_data=%h stall_n=%b; expected addr=%h data=%h tag=%0d stall_n=%0d",
                  who, e.is_wr ? "write" : "fill", e.ch, dwr, twr, wack, mwr, maddr, mwd,
                  faddr, fdata, stl, e.addr, e.data, e.tag, e.stall);
      end
   endtask

   // monitor for the two-channel instance
   always @(negedge clk) begin
      if ((data_wr | tag_wr | wr_ack) != 2'b00 || mainmem_wr) begin
         if (sb0.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut2_unexpected: data_wr=%b tag_wr=%b wr_ack=%b mm_wr=%b, expected no event",
                     data_wr, tag_wr, wr_ack, mainmem_wr);
         end else begin
            sb_cmp("dut2", sb0.pop_front(), {2'b00, data_wr}, {2'b00, tag_wr}, {2'b00, wr_ack},
                   mainmem_wr, mainmem_addr, mainmem_write_data, fill_addr, fill_data, stall_n);
         end
      end
      if (data_wr != 2'b00) ret_seen++;
   end

   // monitor for the four-channel instance
   always @(negedge clk) begin
      if ((data_wr4 | tag_wr4 | wr_ack4) != 4'b0000 || mm_wr4) begin
         if (sb4.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut4_unexpected: data_wr=%b tag_wr=%b wr_ack=%b, expected no event",
                     data_wr4, tag_wr4, wr_ack4);
         end else begin
            sb_cmp("dut4", sb4.pop_front(), data_wr4, tag_wr4, wr_ack4, mm_wr4, mm_addr4,
                   mm_wdata4, fill_addr4, fill_data4, stall_n4);
         end
      end
   end

   task automatic push_fill(input int which, input int ch, input logic [15:0] base, input int words);
      exp_t e;
      for (int k = 0; k < words; k++) begin
         e.is_wr = 1'b0;
         e.ch    = ch;
         e.addr  = base + 16'(2 * k);
         e.data  = mem_f(e.addr);
         e.tag   = (k == words - 1);
         e.stall = 1'b0;
         if (which == 4) sb4.push_back(e);
         else sb0.push_back(e);
      end
   endtask

   task automatic push_wr(input int ch, input logic [15:0] a, input logic [15:0] d, input bit stl);
      exp_t e;
      e.is_wr = 1'b1;
      e.ch    = ch;
      e.addr  = a;
      e.data  = d;
      e.tag   = 1'b0;
      e.stall = stl;
      sb0.push_back(e);
   endtask

   // one clock: requesters drop their level requests once acknowledged
   task automatic tick();
      @(negedge clk);
      miss_req  = miss_req & ~tag_wr;
      wr_req    = wr_req & ~wr_ack;
      miss_req4 = miss_req4 & ~tag_wr4;
      if (mainmem_data_valid && busy == 2'b00) late_valid++;
      #1;
   endtask

   task automatic wait_drain(input string name, input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         tick();
         done = (sb0.size() == 0) && (sb4.size() == 0) && (busy == 2'b00) && (busy4 == 4'b0000);
      end
      check(name, 64'(done), 64'(1'b1));
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_strobes"}, 64'({data_wr, tag_wr, wr_ack, busy}), 64'(8'h00));
      check({name, "_stall_n"}, 64'(stall_n), 64'(1'b1));
      check({name, "_fill"}, 64'({fill_data, fill_addr}), 64'(32'h0));
      check({name, "_mm"}, 64'({mainmem_addr, mainmem_write_data, mainmem_wr, mainmem_enable}), 64'(34'h0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst_n = 1'b0;
      miss_req = 2'b00; wr_req = 2'b00; miss_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0;
      miss_req4 = 4'b0000; wr_req4 = 4'b0000; miss_addr4 = 64'h0; wr_addr4 = 64'h0; wr_data4 = 64'h0;
      tick();
      check_reset_vals("reset");
      check("reset_dut4", 64'({busy4, data_wr4, tag_wr4, wr_ack4, stall_n4, mm_en4}), 64'(18'h2));
      rst_n = 1'b1;
      tick();

      // single icache miss at 0x0013: block 0x0010..0x001E
      miss_addr[15:0] = 16'h0013;
      miss_req = 2'b01;
      push_fill(0, 0, 16'h0010, 8);
      #1;
      check("t1_stall_req", 64'(stall_n), 64'(1'b0));
      for (int k = 1; k <= 14; k++) begin
         tick();
         check($sformatf("t1_busy_c%0d", k), 64'(busy), 64'((k <= 12) ? 2'b01 : 2'b00));
         check($sformatf("t1_stall_c%0d", k), 64'(stall_n), 64'(k >= 13));
         check($sformatf("t1_en_c%0d", k), 64'(mainmem_enable), 64'(k <= 8));
         check($sformatf("t1_tag_c%0d", k), 64'(tag_wr), 64'((k == 12) ? 2'b01 : 2'b00));
         if (k <= 8)
            check($sformatf("t1_mmaddr_c%0d", k), 64'(mainmem_addr), 64'(16'h0010 + 16'(2 * (k - 1))));
      end
      wait_drain("t1_drain", 20);

      // simultaneous misses from reset: ch0 then ch1, then ch0 again
      do_reset();
      miss_addr = {16'h8123, 16'h0345};
      miss_req = 2'b11;
      push_fill(0, 0, 16'h0340, 8);
      push_fill(0, 1, 16'h8120, 8);
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 13) begin
            check("t2_busy_idle", 64'(busy), 64'(2'b00));
            check("t2_stall_idle", 64'(stall_n), 64'(1'b0));
         end
         if (k == 14) check("t2_busy_ch1", 64'(busy), 64'(2'b10));
      end
      wait_drain("t2_drain_a", 60);
      miss_addr = {16'h9FF0, 16'h7777};
      miss_req = 2'b11;
      push_fill(0, 0, 16'h7770, 8);
      push_fill(0, 1, 16'h9FF0, 8);
      wait_drain("t2_drain_b", 60);

      // ch1 write-through arriving during ch0 fill waits for the fill
      miss_addr[15:0] = 16'h3456;
      miss_req = 2'b01;
      push_fill(0, 0, 16'h3450, 8);
      tick();
      tick();
      tick();
      wr_addr[31:16] = 16'h4002;
      wr_data[31:16] = 16'hBEEF;
      wr_req = 2'b10;
      push_wr(1, 16'h4002, 16'hBEEF, 1'b1);
      wait_drain("t3_drain", 40);

      // same channel write + miss: write first
      wr_addr[15:0] = 16'h5554;
      wr_data[15:0] = 16'h1234;
      miss_addr[15:0] = 16'h6009;
      wr_req = 2'b01;
      miss_req = 2'b01;
      push_wr(0, 16'h5554, 16'h1234, 1'b0);
      push_fill(0, 0, 16'h6000, 8);
      wait_drain("t4_drain", 40);

      // async reset at the 3rd return; stale returns afterwards must be ignored
      n0 = ret_seen;
      miss_addr[15:0] = 16'h0A47;
      miss_req = 2'b01;
      push_fill(0, 0, 16'h0A40, 8);
      for (int i = 0; i < 40 && ret_seen < n0 + 3; i++) tick();
      check("t5_third_return", 64'(ret_seen - n0), 64'(3));
      late_valid = 0;
      rst_n = 1'b0;
      miss_req = 2'b00;
      #1;
      check_reset_vals("t5_async");
      sb0.delete();
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t5_late_valid_seen", 64'(late_valid > 0), 64'(1'b1));
      check("t5_idle_after", 64'({busy, stall_n}), 64'(3'b001));

      // four channels, 4-word blocks: grants 0,1,2,3
      miss_addr4 = {16'hFFFB, 16'h3007, 16'h203F, 16'h1005};
      miss_req4 = 4'b1111;
      push_fill(4, 0, 16'h1000, 4);
      push_fill(4, 1, 16'h2038, 4);
      push_fill(4, 2, 16'h3000, 4);
      push_fill(4, 3, 16'hFFF8, 4);
      wait_drain("t6_drain", 100);
      check("t6_stall_n", 64'(stall_n4), 64'(1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
